// File: rtl/calc_controller.sv
// calc_controller: multi-cycle fetch/decode/execute control FSM driving the calculator datapath.
// Ports:
//   clk_i          - clock, rising edge
//   reset_ni       - asynchronous active-low reset
//   run_i          - 1 = execute, 0 = stop at the next instruction boundary
//   instr_i        - memory port A read data, captured into ir on the DECODE edge
//   regwrite_o     - register file write strobe
//   wa_o/ra1_o/ra2_o - register addresses ir[11:8], ir[7:4], ir[3:0]
//   aluop_o        - ALU function (ir[14:12] for ALU ops in EXEC/WB, else 0)
//   we_a_o         - port A write enable, tied low (port A is fetch-only)
//   we_b_o         - port B write strobe
//   ld_mux_en_a_o  - register write data from q_b (1) or ALU (0)
//   ld_mux_en_b_o  - port B address from rd1
//   pc_en_o        - PC increment
//   ld_pc_en_o     - PC load from rd1 (jump)
//   pc_mux_o       - port A address from PC
//   state_o        - current state for debug
//   halted_o       - high in HALT
//   illegal_o      - one-cycle pulse on an undefined opcode
module calc_controller (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        run_i,
    input  logic [15:0] instr_i,
    output logic        regwrite_o,
    output logic [3:0]  wa_o,
    output logic [3:0]  ra1_o,
    output logic [3:0]  ra2_o,
    output logic [2:0]  aluop_o,
    output logic        we_a_o,
    output logic        we_b_o,
    output logic        ld_mux_en_a_o,
    output logic        ld_mux_en_b_o,
    output logic        pc_en_o,
    output logic        ld_pc_en_o,
    output logic        pc_mux_o,
    output logic [2:0]  state_o,
    output logic        halted_o,
    output logic        illegal_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;
    logic [2:0]  state_q, state_d, bnd;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  op;
    logic        is_alu, is_ld, is_st, is_jmp, is_hlt, is_ill;
    assign op     = ir_q[15:12];
    assign is_alu = ~op[3];
    assign is_ld  = op == 4'h8;
    assign is_st  = op == 4'h9;
    assign is_jmp = op == 4'hA;
    assign is_hlt = op == 4'hF;
    assign is_ill = op[3] & ~is_ld & ~is_st & ~is_jmp & ~is_hlt;
    // run is only consulted at instruction boundaries, IDLE and HALT
    assign bnd    = run_i ? FETCH : IDLE;
    assign ir_d   = (state_q == DECODE) ? instr_i : ir_q;
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bnd;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = is_alu ? WB : (is_ld | is_st) ? MEM : is_hlt ? HALT : bnd;
            MEM:     state_d = is_ld ? WB : bnd;
            WB:      state_d = bnd;
            HALT:    state_d = run_i ? HALT : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end
    // Moore outputs: decoded from state_q and ir_q only
    assign state_o       = state_q;
    assign wa_o          = ir_q[11:8];
    assign ra1_o         = ir_q[7:4];
    assign ra2_o         = ir_q[3:0];
    assign we_a_o        = 1'b0;
    assign pc_mux_o      = (state_q == FETCH) | (state_q == DECODE);
    assign pc_en_o       = state_q == DECODE;
    assign ld_pc_en_o    = (state_q == EXEC) & is_jmp;
    assign illegal_o     = (state_q == EXEC) & is_ill;
    assign aluop_o       = (((state_q == EXEC) | (state_q == WB)) & is_alu) ? ir_q[14:12] : 3'd0;
    assign ld_mux_en_b_o = (((state_q == EXEC) | (state_q == MEM)) & (is_ld | is_st)) | ((state_q == WB) & is_ld);
    assign we_b_o        = (state_q == MEM) & is_st;
    assign regwrite_o    = state_q == WB;
    assign ld_mux_en_a_o = (state_q == WB) & is_ld;
    assign halted_o      = state_q == HALT;
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: randomized self-checking bench for calc_controller against a per-instruction cycle model.
module tb_calc_controller;
    localparam int B_HALT = 9, B_ILL = 8, B_PCMUX = 7, B_LDPC = 6, B_PCEN = 5;
    localparam int B_LDB = 4, B_LDA = 3, B_WEB = 2, B_WEA = 1, B_RW = 0;
    localparam logic [9:0] HALT_STROBES = 10'h200;
    logic        clk_i = 1'b0;
    logic        reset_ni, run_i;
    logic [15:0] instr_i;
    logic        regwrite_o, we_a_o, we_b_o, ld_mux_en_a_o, ld_mux_en_b_o;
    logic        pc_en_o, ld_pc_en_o, pc_mux_o, halted_o, illegal_o;
    logic [3:0]  wa_o, ra1_o, ra2_o;
    logic [2:0]  aluop_o, state_o;
    int          n_chk = 0, n_fail = 0;
    logic [15:0] prev_w = 16'h0000;

    calc_controller dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .run_i(run_i), .instr_i(instr_i),
        .regwrite_o(regwrite_o), .wa_o(wa_o), .ra1_o(ra1_o), .ra2_o(ra2_o),
        .aluop_o(aluop_o), .we_a_o(we_a_o), .we_b_o(we_b_o),
        .ld_mux_en_a_o(ld_mux_en_a_o), .ld_mux_en_b_o(ld_mux_en_b_o),
        .pc_en_o(pc_en_o), .ld_pc_en_o(ld_pc_en_o), .pc_mux_o(pc_mux_o),
        .state_o(state_o), .halted_o(halted_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [2:0] st, input logic [9:0] str,
                              input logic [2:0] alu, input logic [11:0] addr);
        logic [9:0] s;
        s = {halted_o, illegal_o, pc_mux_o, ld_pc_en_o, pc_en_o, ld_mux_en_b_o,
             ld_mux_en_a_o, we_b_o, we_a_o, regwrite_o};
        chk({tag, ".state"}, 16'(state_o), 16'(st));
        chk({tag, ".strobes"}, 16'(s), 16'(str));
        chk({tag, ".aluop"}, 16'(aluop_o), 16'(alu));
        chk({tag, ".addr"}, 16'({wa_o, ra1_o, ra2_o}), 16'(addr));
    endtask

    // Reference: cycle k of an instruction counted from its FETCH cycle (k=0)
    task automatic check_step(input logic [15:0] w, input int k);
        logic [3:0] op;
        logic [9:0] s;
        logic [2:0] st, alu;
        logic       mem_op;
        op     = w[15:12];
        mem_op = (op == 4'h8) || (op == 4'h9);
        st     = (k < 3) ? 3'(k + 1) : (k == 3 && mem_op) ? 3'd4 : 3'd5;
        s = '0;
        s[B_PCMUX] = k < 2;
        s[B_PCEN]  = k == 1;
        s[B_LDPC]  = k == 2 && op == 4'hA;
        s[B_ILL]   = k == 2 && op inside {[4'hB:4'hE]};
        s[B_LDB]   = k >= 2 && mem_op;
        s[B_LDA]   = k == 4 && op == 4'h8;
        s[B_WEB]   = k == 3 && op == 4'h9;
        s[B_RW]    = (k == 3 && op < 4'h8) || (k == 4 && op == 4'h8);
        alu = (op < 4'h8 && k >= 2) ? w[14:12] : 3'd0;
        expect_all($sformatf("i%h.k%0d", w, k), st, s, alu, (k < 2) ? prev_w[11:0] : w[11:0]);
    endtask

    task automatic run_instr(input logic [15:0] w, input int drop_k);
        int n;
        logic [3:0] op;
        op = w[15:12];
        n  = (op == 4'h8) ? 5 : (op < 4'h8 || op == 4'h9) ? 4 : 3;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            check_step(w, k);
            instr_i = (k < 2) ? w : 16'($urandom);
            if (k == drop_k) run_i = 1'b0;
        end
        prev_w = w;
    endtask

    task automatic do_instr(input logic [15:0] w, input int drop_k, input int halt_len);
        run_instr(w, drop_k);
        if (w[15:12] == 4'hF) begin
            repeat (halt_len) begin
                @(negedge clk_i);
                expect_all("halt", 3'd6, HALT_STROBES, 3'd0, w[11:0]);
            end
            run_i = 1'b0;
            @(negedge clk_i);
            expect_all("halt_exit", 3'd0, 10'd0, 3'd0, w[11:0]);
            run_i = 1'b1;
        end else if (!run_i) begin
            repeat (2) begin
                @(negedge clk_i);
                expect_all("stopped", 3'd0, 10'd0, 3'd0, w[11:0]);
            end
            run_i = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int          drop;
        reset_ni = 1'b0;
        run_i    = 1'b1;
        instr_i  = 16'hBEEF;
        repeat (3) begin
            @(negedge clk_i);
            expect_all("reset", 3'd0, 10'd0, 3'd0, 12'h000);
        end
        reset_ni = 1'b1;
        do_instr(16'h2312, -1, 0);
        do_instr(16'h8540, -1, 0);
        do_instr(16'h9065, -1, 0);
        do_instr(16'hA030, -1, 0);
        do_instr(16'hC000, -1, 0);
        do_instr(16'hF000, -1, 3);
        do_instr(16'h1123, 2, 0);
        run_instr(16'h4ABC, -1);
        #2 reset_ni = 1'b0;
        #1 expect_all("reset_async", 3'd0, 10'd0, 3'd0, 12'h000);
        prev_w = 16'h0000;
        @(negedge clk_i);
        expect_all("reset_hold", 3'd0, 10'd0, 3'd0, 12'h000);
        reset_ni = 1'b1;
        for (int i = 0; i < 150; i++) begin
            w    = 16'($urandom);
            drop = (w[15:12] != 4'hF && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            do_instr(w, drop, int'($urandom_range(1, 4)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
